// File: rtl/watch_pkg.sv
// ---------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch time-setting logic:
//   - state_t        : entry FSM states
//   - POS_*          : digit positions, 0 = h_ten .. 5 = s_one
//   - MAX_DIGIT_TBL  : per-position upper bound, same BCD packing as a time word
//   - get_digit / set_digit : access one BCD digit of a packed 24-bit time
//   - max_digit      : upper bound for a position given the entered hour tens
// ---------------------------------------------------------------------------
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [2:0] POS_H_TEN = 3'd0;
  localparam logic [2:0] POS_H_ONE = 3'd1;
  localparam logic [2:0] POS_M_TEN = 3'd2;
  localparam logic [2:0] POS_M_ONE = 3'd3;
  localparam logic [2:0] POS_S_TEN = 3'd4;
  localparam logic [2:0] POS_S_ONE = 3'd5;

  // Packed like a time word so get_digit() indexes it directly.
  localparam logic [23:0] MAX_DIGIT_TBL = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

  // Time word layout: {h_ten, h_one, m_ten, m_one, s_ten, s_one}, position 0 in the MSBs.
  function automatic logic [3:0] get_digit(input logic [23:0] t, input logic [2:0] pos);
    return 4'(t >> (4 * (5 - int'(pos))));
  endfunction

  function automatic logic [23:0] set_digit(input logic [23:0] t, input logic [2:0] pos,
                                            input logic [3:0] d);
    int unsigned sh;
    sh = 4 * (5 - int'(pos));
    return (t & ~(24'hF << sh)) | (24'(d) << sh);
  endfunction

  // Hour units are limited to 3 once the hour tens reads 2 (20..23 h).
  function automatic logic [3:0] max_digit(input logic [2:0] pos, input logic [3:0] h_ten);
    if (pos == POS_H_ONE && h_ten >= 4'd2) return 4'd3;
    return get_digit(MAX_DIGIT_TBL, pos);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Conditions one raw asynchronous key: 2-FF synchroniser, stability counter
// that accepts a new level after N_DEB consecutive equal samples, and a
// one-cycle press pulse on the 0->1 change of the debounced level.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   key_raw in  raw key level, active-high, asynchronous
//   press   out one-cycle pulse per accepted press (no pulse on release)
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int unsigned N_DEB = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned N  = (N_DEB < 1) ? 1 : N_DEB;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic          sync1, sync2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      // Any sample equal to the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Keypad-driven time-setting controller for the 24 h watch counter.
// '#' opens a six-digit HH:MM:SS entry seeded from the live time; each digit
// is range checked against its position, and the completed time is issued
// to the datapath as a one-cycle load. '#' again, or an idle timeout,
// aborts without loading.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   key_num    in  raw digit keys, bit i = key i
//   key_set    in  raw '#' key
//   cur_time   in  live BCD time {h_ten,h_one,m_ten,m_one,s_ten,s_one}
//   load       out one-cycle load strobe
//   load_time  out BCD time to load, valid while load=1
//   set_active out 1 during ENTRY and COMMIT (datapath halts counting)
//   cursor     out digit position being entered, 0 outside ENTRY
//   blink      out cursor digit visible (1) / blanked (0), 1 outside ENTRY
//   key_err    out one-cycle strobe on a rejected digit
// ---------------------------------------------------------------------------
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 1000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_S   = 10,
  parameter int unsigned BLINK_MS    = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  key_num,
  input  logic        key_set,
  input  logic [23:0] cur_time,
  output logic        load,
  output logic [23:0] load_time,
  output logic        set_active,
  output logic [2:0]  cursor,
  output logic        blink,
  output logic        key_err
);

  localparam int unsigned N_DEB     = DEBOUNCE_MS * CLK_HZ / 1000;
  localparam int unsigned TO_CYC    = (TIMEOUT_S * CLK_HZ < 2) ? 2 : TIMEOUT_S * CLK_HZ;
  localparam int unsigned BLINK_CYC = (BLINK_MS * CLK_HZ / 1000 < 2) ? 2 : BLINK_MS * CLK_HZ / 1000;
  localparam int unsigned TW        = $clog2(TO_CYC);
  localparam int unsigned BW        = $clog2(BLINK_CYC);
  localparam logic [TW-1:0] TO_LAST    = TW'(TO_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  logic [9:0]    dig_press;
  logic          set_press;
  logic          dig_valid;
  logic [3:0]    dig_val;
  logic          dig_ok;
  logic [23:0]   shadow, shadow_acc;
  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] blink_cnt;

  for (genvar i = 0; i < 10; i++) begin : g_dig
    key_debounce #(.N_DEB(N_DEB)) u_dig (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_num[i]),
      .press   (dig_press[i])
    );
  end

  key_debounce #(.N_DEB(N_DEB)) u_set (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key_set),
    .press   (set_press)
  );

  // Simultaneous digit presses are ambiguous and dropped without an error.
  assign dig_valid = $onehot(dig_press);

  // NOTE: every combinational output gets a default before any conditional
  // assignment, otherwise a latch is inferred.
  always_comb begin
    dig_val = '0;
    for (int i = 0; i < 10; i++) begin
      if (dig_press[i]) dig_val = 4'(i);
    end
  end

  assign dig_ok = dig_val <= max_digit(cursor, get_digit(shadow, POS_H_TEN));

  // Shadow after accepting dig_val; choosing 2x h clears an out-of-range h_one.
  always_comb begin
    shadow_acc = set_digit(shadow, cursor, dig_val);
    if (cursor == POS_H_TEN && dig_val == 4'd2 && get_digit(shadow, POS_H_ONE) > 4'd3) begin
      shadow_acc = set_digit(shadow_acc, POS_H_ONE, 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shadow     <= '0;
      to_cnt     <= '0;
      blink_cnt  <= '0;
      load       <= 1'b0;
      load_time  <= '0;
      set_active <= 1'b0;
      cursor     <= '0;
      blink      <= 1'b1;
      key_err    <= 1'b0;
    end else begin
      load    <= 1'b0;
      key_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (set_press) begin
            state      <= ENTRY;
            shadow     <= cur_time;
            set_active <= 1'b1;
            cursor     <= POS_H_TEN;
            blink      <= 1'b1;
            to_cnt     <= '0;
            blink_cnt  <= '0;
          end
        end
        ENTRY: begin
          // Free-running timers; later assignments below take precedence.
          to_cnt <= to_cnt + 1'b1;
          if (blink_cnt == BLINK_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end

          if (set_press || (!dig_valid && to_cnt == TO_LAST)) begin
            state      <= IDLE;
            set_active <= 1'b0;
            cursor     <= '0;
            blink      <= 1'b1;
          end else if (dig_valid) begin
            to_cnt <= '0;
            if (dig_ok) begin
              shadow    <= shadow_acc;
              blink     <= 1'b1;
              blink_cnt <= '0;
              if (cursor == POS_S_ONE) begin
                state     <= COMMIT;
                load      <= 1'b1;
                load_time <= shadow_acc;
                cursor    <= '0;
              end else begin
                cursor <= cursor + 3'd1;
              end
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state      <= IDLE;
          set_active <= 1'b0;
          blink      <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          set_active <= 1'b0;
          cursor     <= '0;
          blink      <= 1'b1;
        end
      endcase
    end
  end

endmodule
